// File: rtl/vga_pkg.sv
// Shared geometry, control codes and state types for the vga text console.
package vga_pkg;

  localparam int VGA_COLS  = 80;
  localparam int VGA_ROWS  = 24;
  localparam int VGA_CELLS = VGA_COLS * VGA_ROWS;
  localparam int VGA_POS_W = 11;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } vga_state_e;

  typedef enum logic [2:0] {
    CUR_HOLD    = 3'd0,
    CUR_ADVANCE = 3'd1,
    CUR_NEWLINE = 3'd2,
    CUR_CR      = 3'd3,
    CUR_BS      = 3'd4,
    CUR_HOME    = 3'd5
  } cur_op_e;

endpackage

// File: rtl/vga_cursor.sv
// Console cursor: row/col kept separately, one operation per cycle,
// registered linear position plus the combinational next position.
module vga_cursor
  import vga_pkg::*;
#(
  parameter int COLS = VGA_COLS,
  parameter int ROWS = VGA_ROWS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  cur_op_e              op_i,
  output logic [VGA_POS_W-1:0] pos_o,
  output logic [VGA_POS_W-1:0] pos_next_o
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  logic [ROW_W-1:0]     row_q, row_d, row_inc;
  logic [COL_W-1:0]     col_q, col_d;
  logic [VGA_POS_W-1:0] pos_q, row_ext, col_ext;

  assign row_inc = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    case (op_i)
      CUR_ADVANCE: begin
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      CUR_NEWLINE: row_d = row_inc;
      CUR_CR:      col_d = '0;
      CUR_BS: begin
        // Backspace at the home cell stays put rather than wrapping.
        if (col_q != '0) begin
          col_d = col_q - 1'b1;
        end else if (row_q != '0) begin
          row_d = row_q - 1'b1;
          col_d = LAST_COL;
        end
      end
      CUR_HOME: begin
        row_d = '0;
        col_d = '0;
      end
      default: ;
    endcase
  end

  assign row_ext = VGA_POS_W'(row_d);
  assign col_ext = VGA_POS_W'(col_d);

  generate
    if (COLS == 80) begin : g_shift_add
      assign pos_next_o = (row_ext << 6) + (row_ext << 4) + col_ext;
    end else begin : g_generic
      assign pos_next_o = VGA_POS_W'(row_ext * VGA_POS_W'(COLS)) + col_ext;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
      pos_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      pos_q <= pos_next_o;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/vga_text_ctrl.sv
// Text console front end: byte handshake, control-code decode and clear sweep
// for the vga write port. VGA_TEXT_CLEAR_ON_RESET_EN blanks the screen on reset exit.
module vga_text_ctrl
  import vga_pkg::*;
#(
  parameter int         COLS  = VGA_COLS,
  parameter int         ROWS  = VGA_ROWS,
  parameter logic [7:0] BLANK = GLYPH_BLANK
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           write_char,
  output logic [VGA_POS_W-1:0] write_char_pos,
  output logic                 write_char_strobe,
  output logic [VGA_POS_W-1:0] cursor_pos,
  output logic                 busy
);

  // One spare bit so the counter can reach COLS*ROWS itself (end-of-sweep marker).
  localparam int                 SWEEP_W = VGA_POS_W + 1;
  localparam logic [SWEEP_W-1:0] CELLS   = SWEEP_W'(COLS * ROWS);

`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
  localparam vga_state_e RST_STATE = ST_CLEAR;
  localparam logic       RST_BUSY  = 1'b1;
`else
  localparam vga_state_e RST_STATE = ST_IDLE;
  localparam logic       RST_BUSY  = 1'b0;
`endif

  vga_state_e           state_q, state_d;
  logic [SWEEP_W-1:0]   sweep_q, sweep_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 strobe_q, strobe_d;
  logic [7:0]           char_q, char_d;
  logic [VGA_POS_W-1:0] wpos_q, wpos_d;
  logic                 accept;
  cur_op_e              cur_op;
  logic [VGA_POS_W-1:0] cur_pos, cur_pos_next;

  vga_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .op_i       (cur_op),
    .pos_o      (cur_pos),
    .pos_next_o (cur_pos_next)
  );

  assign accept = in_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    char_d   = char_q;
    wpos_d   = wpos_q;
    cur_op   = CUR_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (in_data)
            CH_CR: cur_op = CUR_CR;
            CH_LF: cur_op = CUR_NEWLINE;
            CH_BS: begin
              cur_op   = CUR_BS;
              strobe_d = 1'b1;
              char_d   = BLANK;
              wpos_d   = cur_pos_next;
            end
            CH_FF: begin
              // Cell 0 is written on the accept edge itself so the sweep
              // strobes start the very next cycle.
              state_d  = ST_CLEAR;
              busy_d   = 1'b1;
              strobe_d = 1'b1;
              char_d   = BLANK;
              wpos_d   = '0;
              sweep_d  = SWEEP_W'(1);
            end
            default: begin
              cur_op   = CUR_ADVANCE;
              strobe_d = 1'b1;
              char_d   = in_data;
              wpos_d   = cur_pos;
            end
          endcase
        end
      end
      ST_CLEAR: begin
        if (sweep_q == CELLS) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cur_op  = CUR_HOME;
        end else begin
          strobe_d = 1'b1;
          char_d   = BLANK;
          wpos_d   = sweep_q[VGA_POS_W-1:0];
          sweep_d  = sweep_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_d = (state_d == ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= RST_STATE;
      sweep_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= RST_BUSY;
      strobe_q <= 1'b0;
      char_q   <= BLANK;
      wpos_q   <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      char_q   <= char_d;
      wpos_q   <= wpos_d;
    end
  end

  assign in_ready          = ready_q;
  assign busy              = busy_q;
  assign write_char        = char_q;
  assign write_char_pos    = wpos_q;
  assign write_char_strobe = strobe_q;
  assign cursor_pos        = cur_pos;

endmodule
